stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter P_DIV, default 320000, clk cycles per counter tick (10 ms at 32 MHz); legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 btn_ss  input  1  start/stop request, debounced, one-cycle pulse.
REQ-005 btn_lr  input  1  lap/reset request, debounced, one-cycle pulse.
REQ-006 all_max_i  input  1  every digit of the counter chain at its maximum; combinational from counts only, independent of en_tick.
REQ-007 en_tick  output  1  enable for the least-significant digit counter, one cycle per tick.
REQ-008 cnt_init  output  1  synchronous clear, level, to every digit counter.
REQ-009 disp_hold  output  1  freeze the display register (lap view).
REQ-010 state_o  output  2  current state code, for status LEDs.

Function
REQ-011 The FSM SHALL have states IDLE=0, RUN=1, STOP=2, LAP=3.
REQ-012 IDLE: btn_ss -> RUN; btn_lr ignored.
REQ-013 RUN: btn_ss -> STOP; btn_lr -> LAP.
REQ-014 LAP: btn_lr -> RUN; btn_ss -> STOP.
REQ-015 STOP: btn_ss -> RUN; btn_lr -> IDLE.
REQ-016 When btn_ss and btn_lr are high in the same cycle, btn_ss SHALL win and btn_lr SHALL be discarded.
REQ-017 Prescaler pre: counts 0..P_DIV-1 and wraps to 0 while in RUN or LAP; holds its value in STOP (fractional phase kept); cleared to 0 in IDLE.
REQ-018 en_tick SHALL be combinational: (state is RUN or LAP) and pre==P_DIV-1 and all_max_i==0.
REQ-019 Overflow: in RUN or LAP with pre==P_DIV-1 and all_max_i==1, en_tick SHALL stay 0 and the next state SHALL be STOP (display saturates at all-max, no wrap to zero).
REQ-020 A tick due in the same cycle as a btn_ss in RUN SHALL still be issued; the state change takes effect on the next edge.
REQ-021 cnt_init SHALL be registered and equal 1 exactly when state is IDLE.
REQ-022 disp_hold SHALL be registered and equal 1 exactly when state is LAP; counting continues underneath.
REQ-023 The first en_tick after IDLE->RUN SHALL occur P_DIV cycles after the transition edge.
REQ-024 pre SHALL be ceil(log2(P_DIV)) bits wide, compared for equality only, with no overflow past P_DIV-1.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, pre=0, cnt_init=1, disp_hold=0, state_o=0; en_tick then evaluates to 0.
REQ-026 Reset assertion mid-RUN or mid-LAP SHALL abort immediately with no further en_tick; release SHALL be synchronous to clk.

Structure
REQ-027 State codes and the P_DIV default SHALL live in shared package stopwatch_pkg.
REQ-028 The prescaler SHALL be a sub-module tick_gen (inputs clk, rst_n, run, clr; output wrap flag); the FSM and output decode SHALL stay in stopwatch_ctrl.

Verification (P_DIV=4)
REQ-029 Reset, then idle 10 cycles -> cnt_init=1, en_tick=0, state_o=0 throughout.
REQ-030 btn_ss, then run 12 cycles -> en_tick pulses 4, 8 and 12 cycles after the IDLE->RUN edge; cnt_init=0.
REQ-031 RUN, btn_ss when pre=2, wait 5 cycles, btn_ss -> en_tick exactly 2 cycles after resume (phase kept).
REQ-032 RUN, btn_lr -> disp_hold=1 from next cycle while en_tick keeps pulsing; second btn_lr -> disp_hold=0.
REQ-033 RUN with all_max_i=1 at pre=3 -> no en_tick, state_o=2 next cycle; then btn_lr -> state_o=0 and cnt_init=1.
REQ-034 btn_ss and btn_lr together in RUN -> STOP; rst_n pulsed low mid-RUN -> IDLE immediately, no en_tick.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state codes, default
// prescaler ratio and a small state-classification helper.
package stopwatch_pkg;

  // Default prescaler ratio: 10 ms ticks from a 32 MHz clock.
  localparam int unsigned P_DIV_DEFAULT = 320000;

  // State codes double as the status-LED encoding on state_o.
  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_LAP  = 2'd3;

  // True in the states where time advances (LAP keeps counting underneath).
  function automatic logic is_counting(input state_t s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the stopwatch: counts 0..P_DIV-1 while running, freezes
// while paused so the fractional phase survives a stop, clears on request.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned P_DIV = P_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned W    = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(P_DIV - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;

  // Terminal count; equality only, the counter never passes LAST.
  assign wrap = (pre_q == LAST);

  // Next prescaler value: clear has priority, otherwise count with wrap or hold.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = wrap ? '0 : pre_q + W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/reset buttons, tick enable for
// the digit chain, saturation at all-max, counter clear and lap display hold.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned P_DIV = P_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       all_max_i,
  output logic       en_tick,
  output logic       cnt_init,
  output logic       disp_hold,
  output logic [1:0] state_o
);

  state_t state_q;
  state_t state_d;
  logic   cnt_init_q;
  logic   disp_hold_q;
  logic   counting;
  logic   wrap;
  logic   overflow;

  assign counting = is_counting(state_q);

  tick_gen #(
    .P_DIV (P_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (counting),
    .clr   (state_q == S_IDLE),
    .wrap  (wrap)
  );

  // A tick that would push an all-max chain over is suppressed and the
  // watch stops instead, so the display saturates rather than rolling over.
  assign overflow = counting && wrap && all_max_i;
  assign en_tick  = counting && wrap && !all_max_i;

  // Next-state logic; btn_ss is checked first so it wins over btn_lr.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (overflow || btn_ss) state_d = S_STOP;
        else if (btn_lr)        state_d = S_LAP;
      end
      S_LAP: begin
        if (overflow || btn_ss) state_d = S_STOP;
        else if (btn_lr)        state_d = S_RUN;
      end
      S_STOP: begin
        if (btn_ss)      state_d = S_RUN;
        else if (btn_lr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered output decode, both derived from the next state so
  // the outputs line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_init_q  <= 1'b1;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_init_q  <= (state_d == S_IDLE);
      disp_hold_q <= (state_d == S_LAP);
    end
  end

  assign cnt_init  = cnt_init_q;
  assign disp_hold = disp_hold_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with P_DIV=4. Outputs are packed as
// {en_tick, state_o[1:0], cnt_init, disp_hold}; each vector describes the
// inputs held during one clock cycle and the outputs expected in that cycle.
module tb_stopwatch_ctrl;

  localparam int unsigned P_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_ss;
  logic       btn_lr;
  logic       all_max_i;
  logic       en_tick;
  logic       cnt_init;
  logic       disp_hold;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       ss;
    logic       lr;
    logic       am;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb_q[$];

  stopwatch_ctrl #(
    .P_DIV (P_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .all_max_i (all_max_i),
    .en_tick   (en_tick),
    .cnt_init  (cnt_init),
    .disp_hold (disp_hold),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic add(input string nm, input int ss, input int lr, input int am,
                     input int en, input int st, input int ci, input int dh);
    vec_t v;
    v.name = nm;
    v.ss   = ss[0];
    v.lr   = lr[0];
    v.am   = am[0];
    v.exp  = {en[0], st[1:0], ci[0], dh[0]};
    vecs.push_back(v);
  endtask

  task automatic compare(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {en_tick, state_o, cnt_init, disp_hold};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en_tick=%0b state_o=%0d cnt_init=%0b disp_hold=%0b, expected en_tick=%0b state_o=%0d cnt_init=%0b disp_hold=%0b",
               nm, act[4], act[3:2], act[1], act[0], exp[4], exp[3:2], exp[1], exp[0]);
    end else begin
      $display("[%0t] %s: en_tick=%0b state_o=%0d cnt_init=%0b disp_hold=%0b ok",
               $time, nm, act[4], act[3:2], act[1], act[0]);
    end
  endtask

  // Drive each vector on the falling edge, queue its expectation, then pop
  // and compare once the combinational outputs have settled.
  task automatic apply_all();
    logic [4:0] exp;
    foreach (vecs[i]) begin
      @(negedge clk);
      btn_ss    = vecs[i].ss;
      btn_lr    = vecs[i].lr;
      all_max_i = vecs[i].am;
      sb_q.push_back(vecs[i].exp);
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty, got no expectation, required one", vecs[i].name);
      end else begin
        exp = sb_q.pop_front();
        compare(vecs[i].name, exp);
      end
    end
    vecs.delete();
    btn_ss    = 1'b0;
    btn_lr    = 1'b0;
    all_max_i = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    btn_ss    = 1'b0;
    btn_lr    = 1'b0;
    all_max_i = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1 compare("reset_async", 5'b0_00_1_0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare("reset_release", 5'b0_00_1_0);

    // Idle for 10 cycles; a lap/reset press in IDLE is ignored.
    for (int i = 0; i < 10; i++) add("idle", 0, (i == 5) ? 1 : 0, 0, 0, 0, 1, 0);
    // Start, then 12 running cycles with ticks in cycles 4, 8 and 12.
    add("start", 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) add("run_tick", 0, 0, 0, (i % 4 == 3) ? 1 : 0, 1, 0, 0);
    // Lap: display frozen while ticks continue, second press returns to RUN.
    add("lap_press", 0, 1, 0, 0, 1, 0, 0);
    add("lap_pre1", 0, 0, 0, 0, 3, 0, 1);
    add("lap_pre2", 0, 0, 0, 0, 3, 0, 1);
    add("lap_tick", 0, 0, 0, 1, 3, 0, 1);
    add("lap_release", 0, 1, 0, 0, 3, 0, 1);
    add("run_pre1", 0, 0, 0, 0, 1, 0, 0);
    add("run_pre2", 0, 0, 0, 0, 1, 0, 0);
    add("run_tick", 0, 0, 0, 1, 1, 0, 0);
    add("run_pre0", 0, 0, 0, 0, 1, 0, 0);
    // Pause so that the prescaler holds 2 in STOP, wait 5, resume.
    add("pause", 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add("stop_hold", 0, 0, 0, 0, 2, 0, 0);
    add("resume", 1, 0, 0, 0, 2, 0, 0);
    add("resume_c1", 0, 0, 0, 0, 1, 0, 0);
    add("resume_c2_tick", 0, 0, 0, 1, 1, 0, 0);
    add("run_pre0", 0, 0, 0, 0, 1, 0, 0);
    add("run_pre1", 0, 0, 0, 0, 1, 0, 0);
    add("run_pre2", 0, 0, 0, 0, 1, 0, 0);
    // Tick due in the same cycle as a stop press is still issued.
    add("stop_on_tick", 1, 0, 0, 1, 1, 0, 0);
    add("stop_hold", 0, 0, 0, 0, 2, 0, 0);
    add("resume", 1, 0, 0, 0, 2, 0, 0);
    // Overflow: all_max mid-period does nothing, at the tick it stops the watch.
    add("run_pre0", 0, 0, 0, 0, 1, 0, 0);
    add("allmax_early", 0, 0, 1, 0, 1, 0, 0);
    add("run_pre2", 0, 0, 0, 0, 1, 0, 0);
    add("overflow", 0, 0, 1, 0, 1, 0, 0);
    add("sat_stop", 0, 0, 1, 0, 2, 0, 0);
    add("stop_clear", 0, 1, 1, 0, 2, 0, 0);
    add("idle_after_clear", 0, 0, 1, 0, 0, 1, 0);
    // Overflow while in LAP also stops and drops the hold.
    add("start", 1, 0, 0, 0, 0, 1, 0);
    add("lap_press", 0, 1, 0, 0, 1, 0, 0);
    add("lap_pre1", 0, 0, 0, 0, 3, 0, 1);
    add("lap_pre2", 0, 0, 0, 0, 3, 0, 1);
    add("lap_overflow", 0, 0, 1, 0, 3, 0, 1);
    add("sat_stop", 0, 0, 0, 0, 2, 0, 0);
    add("stop_clear", 0, 1, 0, 0, 2, 0, 0);
    add("idle", 0, 0, 0, 0, 0, 1, 0);
    // Start/stop from LAP goes to STOP.
    add("start", 1, 0, 0, 0, 0, 1, 0);
    add("lap_press", 0, 1, 0, 0, 1, 0, 0);
    add("lap_stop", 1, 0, 0, 0, 3, 0, 1);
    add("stop_hold", 0, 0, 0, 0, 2, 0, 0);
    add("stop_clear", 0, 1, 0, 0, 2, 0, 0);
    add("idle", 0, 0, 0, 0, 0, 1, 0);
    // Both buttons together: start/stop wins in IDLE, RUN and STOP.
    add("both_idle", 1, 1, 0, 0, 0, 1, 0);
    add("both_run", 1, 1, 0, 0, 1, 0, 0);
    add("stop_hold", 0, 0, 0, 0, 2, 0, 0);
    add("both_stop", 1, 1, 0, 0, 2, 0, 0);
    add("run_pre1", 0, 0, 0, 0, 1, 0, 0);
    add("run_pre2", 0, 0, 0, 0, 1, 0, 0);
    apply_all();

    // Reset asserted mid-RUN with a tick pending aborts immediately.
    @(negedge clk);
    #1 compare("tick_before_reset", 5'b1_01_0_0);
    #2 rst_n = 1'b0;
    #1 compare("reset_mid_run", 5'b0_00_1_0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 compare("reset_held", 5'b0_00_1_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare("reset_release2", 5'b0_00_1_0);

    // After reset the first tick again lands P_DIV cycles after the start edge.
    add("idle", 0, 0, 0, 0, 0, 1, 0);
    add("start", 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add("restart_tick", 0, 0, 0, (i == 3) ? 1 : 0, 1, 0, 0);
    apply_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
